// File: rtl/fir8_window_feeder_pkg.sv
// Shared constants and state type for the 8-tap FIR window feeder.
// The window is TAPS samples of DW bits each, packed newest-first from the LSB.
package fir8_pkg;
  localparam int TAPS   = 8;
  localparam int DW     = 16;
  localparam int WIN_W  = TAPS * DW;
  localparam int FILL_W = $clog2(TAPS + 1);

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } fir8_state_e;
endpackage

// File: rtl/fir8_window_feeder_if.sv
// Sample-in / window-out handshake bundle for the FIR window feeder.
// The slave modport is the feeder itself; the master modport is the environment driving it.
import fir8_pkg::*;

interface fir8_window_feeder_if;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIN_W-1:0] m_window;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_window
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_window
  );
endinterface

// File: rtl/fir8_window_feeder_tap_shreg.sv
// TAPS x DW tap shift register: the newest sample enters at the LSB slot.
// It has an enable and a synchronous clear, and the window output is registered.
module fir8_tap_shreg #(
  parameter int TAPS = 8,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [DW-1:0]      din,
  output logic [TAPS*DW-1:0] window
);
  logic [TAPS-1:0][DW-1:0] taps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q <= '0;
    end else if (clr) begin
      taps_q <= '0;
    end else if (en) begin
      taps_q <= {taps_q[TAPS-2:0], din};
    end
  end

  assign window = taps_q;
endmodule

// File: rtl/fir8_window_feeder.sv
// Streaming front end for the 8-tap FIR: it primes a tap window, then emits one window per accepted sample.
// Defining FIR8_FEEDER_DECIM2_EN turns on decimate-by-2, so every other accept in RUN emits a window.
module fir8_window_feeder
  import fir8_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  fir8_window_feeder_if.slave bus,
  output logic [FILL_W-1:0]   fill_count
);
  fir8_state_e       state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              m_valid_q, m_valid_d;
  logic              accept;
  logic              filling;
  logic              advancing;
  logic              emit;

  assign bus.s_ready = !flush && (!m_valid_q || bus.m_ready);
  assign accept      = bus.s_valid && bus.s_ready;
  assign filling     = (state_q == PRIME) && (fill_q == FILL_W'(TAPS - 1));
  // An advancing accept is any accept that leaves a complete window behind it.
  assign advancing   = accept && ((state_q == RUN) || filling);

`ifdef FIR8_FEEDER_DECIM2_EN
  logic phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
    end else if (flush) begin
      phase_q <= 1'b0;
    end else if (advancing) begin
      phase_q <= ~phase_q;
    end
  end

  assign emit = advancing && !phase_q;
`else
  assign emit = advancing;
`endif

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    m_valid_d = m_valid_q;
    if (flush) begin
      state_d   = PRIME;
      fill_d    = '0;
      m_valid_d = 1'b0;
    end else begin
      if (accept && (fill_q != FILL_W'(TAPS))) begin
        fill_d = fill_q + 1'b1;
      end
      if (accept && filling) begin
        state_d = RUN;
      end
      if (emit) begin
        m_valid_d = 1'b1;
      end else if (bus.m_ready) begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PRIME;
      fill_q    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      m_valid_q <= m_valid_d;
    end
  end

  fir8_tap_shreg #(
    .TAPS (TAPS),
    .DW   (DW)
  ) u_tap_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .en     (accept),
    .din    (bus.s_data),
    .window (bus.m_window)
  );

  assign bus.m_valid = m_valid_q;
  assign fill_count  = fill_q;
endmodule

// File: tb/tb_fir8_window_feeder.sv
// Scoreboard bench for fir8_window_feeder: the stimulus pushes expected windows, and the monitor pops them on each handshake.
module tb_fir8_window_feeder;
  import fir8_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [FILL_W-1:0] fill_count;

  fir8_window_feeder_if bus ();

  fir8_window_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus.slave),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               pushes = 0;
  int               pops   = 0;
  int               acc_cnt = 0;
  logic [WIN_W-1:0] exp_q[$];
  logic [DW-1:0]    hist[TAPS];

  task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] model_win();
    logic [WIN_W-1:0] w;
    for (int j = 0; j < TAPS; j++) w[j*DW +: DW] = hist[j];
    return w;
  endfunction

  function automatic bit emits(input int k);
`ifdef FIR8_FEEDER_DECIM2_EN
    return (k >= TAPS) && (((k - TAPS) % 2) == 0);
`else
    return k >= TAPS;
`endif
  endfunction

  function automatic int fir_dot(input logic [WIN_W-1:0] w);
    int s = 0;
    for (int j = 0; j < TAPS; j++) s += (j + 1) * int'(w[j*DW +: DW]);
    return s;
  endfunction

  task automatic clear_model();
    acc_cnt = 0;
    for (int j = 0; j < TAPS; j++) hist[j] = '0;
  endtask

  task automatic record(input logic [DW-1:0] v);
    for (int j = TAPS - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = v;
    acc_cnt++;
    if (emits(acc_cnt)) begin
      exp_q.push_back(model_win());
      pushes++;
    end
  endtask

  // Entered just after a rising edge; returns at the edge where the sample was taken, plus #1.
  task automatic send(input logic [DW-1:0] v);
    bit ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (ok) begin
      @(posedge clk);
      record(v);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready=0 for sample %h expected 1", v);
    end
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic do_flush();
    #1;
    flush       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hDEAD;
    #1;
    check("flush_s_ready", bus.s_ready, 0);
    @(posedge clk);
    clear_model();
    #1;
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    check("flush_fill", fill_count, 0);
    check("flush_window", bus.m_window, 0);
    check("flush_m_valid", bus.m_valid, 0);
  endtask

  initial begin : monitor
    logic [WIN_W-1:0] exp;
    forever begin
      @(negedge clk);
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got %h expected none", bus.m_window);
        end else begin
          exp = exp_q.pop_front();
          pops++;
          $display("window %0d: %h", pops, bus.m_window);
          check("window", bus.m_window, exp);
        end
      end
    end
  end

  initial begin : stim
    logic [DW-1:0]    stall_v;
    logic [WIN_W-1:0] exp_stall;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    clear_model();

    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_window", bus.m_window, 0);
    check("rst_fill", fill_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_s_ready", bus.s_ready, 1);

    // Priming with samples 1..8, then sample 9
    for (int v = 1; v <= 8; v++) send(16'(v));
    #1;
    check("prime_m_valid", bus.m_valid, 1);
    check("prime_window", bus.m_window, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
    check("prime_fill", fill_count, 8);
    send(16'd9);
    #1;
    check("fir_dot_156", 128'(fir_dot(bus.m_window)), 128'd156);
    check("s9_m_valid", bus.m_valid, emits(acc_cnt) ? 1 : 0);
`ifdef FIR8_FEEDER_DECIM2_EN
    send(16'd10);
    stall_v = 16'd11;
`else
    stall_v = 16'd10;
`endif

    // Backpressure for five cycles, with a sample waiting
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = stall_v;
    exp_stall   = model_win();
    repeat (5) begin
      @(negedge clk);
      check("stall_s_ready", bus.s_ready, 0);
      check("stall_m_valid", bus.m_valid, 1);
      check("stall_window", bus.m_window, exp_stall);
    end
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
    @(negedge clk);
    check("release_s_ready", bus.s_ready, 1);
    @(posedge clk);
    record(stall_v);
    #1;
    bus.s_valid = 1'b0;
    check("release_window", bus.m_window, model_win());
    check("release_m_valid", bus.m_valid, emits(acc_cnt) ? 1 : 0);

    // Flush in RUN, then flush after three samples
    do_flush();
    for (int v = 1; v <= 3; v++) send(16'h0A00 + 16'(v));
    #1;
    check("partial_fill", fill_count, 3);
    do_flush();
    for (int v = 100; v <= 106; v++) send(16'(v));
    #1;
    check("seven_m_valid", bus.m_valid, 0);
    check("seven_fill", fill_count, 7);
    bus.m_ready = 1'b0;
    send(16'd107);
    #1;
    check("refill_m_valid", bus.m_valid, 1);
    check("refill_window", bus.m_window, model_win());

    // Asynchronous reset with a pending, unacknowledged window
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", bus.m_valid, 0);
    check("async_rst_window", bus.m_window, 0);
    check("async_rst_fill", fill_count, 0);
    exp_q.delete();
    pushes = pops;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    check("post_rst_s_ready", bus.s_ready, 1);
    for (int v = 200; v <= 206; v++) send(16'(v));
    #1;
    check("reprime_m_valid_low", bus.m_valid, 0);
    send(16'd207);
    #1;
    check("reprime_m_valid", bus.m_valid, 1);
    check("reprime_window", bus.m_window, 128'h00C8_00C9_00CA_00CB_00CC_00CD_00CE_00CF);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 0);
    check("push_pop_balance", 128'(pops), 128'(pushes));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fir8_window_feeder.md
# fir8_window_feeder

Streaming front end for the 8-tap 16-bit FIR datapath: accepts one 16-bit sample per handshake and assembles the 128-bit parallel tap window that the FIR adder tree consumes. Builds the window in a tap shift register, suppresses output until all taps are primed, then presents a registered window per accepted sample under valid/ready flow control. Sits between the sample source and the combinational FIR, and is the writer of its `data_in` bus.

## Interface
- `TAPS`, 8, number of taps in the window
- `DW`, 16, sample width; window width `WIN_W = TAPS*DW` (128)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous clear of window and fill state
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  block can accept a sample
- `s_data`  in  DW  input sample, unsigned
- `m_valid`  out  1  `m_window` holds a new complete window
- `m_ready`  in  1  downstream accepts window
- `m_window`  out  WIN_W  tap window, newest sample at `[DW-1:0]`, oldest at `[WIN_W-1:WIN_W-DW]`
- `fill_count`  out  $clog2(TAPS+1)  samples currently in window, saturates at TAPS

## Operation
- States: `PRIME` (fill_count < TAPS), `RUN` (window full).
- Sample accept = `s_valid && s_ready`. On accept: window shifts up by DW, `s_data` enters `[DW-1:0]`, oldest sample discarded; fill_count increments, saturating at TAPS.
- `s_ready = !flush && (!m_valid || m_ready)`.
- PRIME: `m_valid` stays 0; the accept that raises fill_count to TAPS moves to RUN and sets `m_valid` next cycle.
- RUN: every emitting accept sets `m_valid`; `m_valid` clears on `m_ready` without a new emitting accept.
- Simultaneous `m_ready` and emitting accept while `m_valid`=1: window updates, `m_valid` stays 1 (back-to-back, one window per cycle).
- Backpressure: while `m_valid && !m_ready`, `s_ready`=0 and `m_window` is held bit-stable.
- `flush`: next cycle window = 0, fill_count = 0, `m_valid` = 0, state PRIME, decimation phase = 0; any `s_valid` in the flush cycle is dropped (`s_ready`=0). Flush overrides a pending unacked window.
- No arithmetic on samples; pure data movement, no width growth.

## Timing
- Reset (async assert, sync-deasserted upstream): `m_window`=0, `m_valid`=0, `fill_count`=0, state PRIME, phase 0; `s_ready`=1 after reset release.
- Latency: accept in cycle N → updated `m_window`/`m_valid` visible in cycle N+1 (all outputs registered except `s_ready`).
- Throughput: one sample per cycle in RUN when `m_ready` held 1.
- `s_ready` is combinational from `m_valid`, `m_ready`, `flush`; no combinational path from `s_valid` to `s_ready`.
- `rst_n` low mid-stream discards window and pending output immediately.

## Configuration
- `FIR8_FEEDER_DECIM2_EN` defined: decimate-by-2. In RUN a 1-bit phase toggles per accept; only accepts with phase=0 set `m_valid` (the filling accept counts as phase 0, so samples 8, 10, 12… emit). Non-emitting accepts still shift the window and require `s_ready`.
- Not defined: every accept in RUN emits; phase register absent.

## Structure
- Package `fir8_pkg`: `DW`, `TAPS`, `WIN_W` constants, `fir8_state_e` enum {PRIME, RUN}, fill-count width constant.
- One sub-module `fir8_tap_shreg`: TAPS×DW shift register with enable and synchronous clear; the top holds the FSM, fill counter, handshake and decimation phase.

## Test plan
- Reset then samples 1..8, `m_ready`=1 → `m_valid` first high one cycle after sample 8; `m_window` = 0x0001_0002_0003_0004_0005_0006_0007_0008 (MSB to LSB), fill_count=8.
- Continue sample 9 next cycle → `m_valid` stays 1, `m_window` = 0x0002_…_0009; driving FIR gives 1·9+2·8+…+8·2 = 156.
- Full window, `m_ready`=0 for 5 cycles with `s_valid`=1 → `s_ready`=0, `m_window` stable; `m_ready`=1 → sample accepted same cycle, new window next cycle.
- After 3 samples assert `flush` with `s_valid`=1 → sample dropped, fill_count=0, window=0; 8 further samples needed before `m_valid`.
- `rst_n` pulsed low during RUN with `m_valid`=1 → all outputs zero asynchronously; restart requires full priming.
- With `FIR8_FEEDER_DECIM2_EN`: samples 1..12, `m_ready`=1 → windows emitted after samples 8, 10, 12 only (3 windows); `m_valid` low after 9 and 11.
